req_queue: RTL

REQ_QUEUE -- requirements
Module: req_queue

---
 rtl/req_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/req_queue.sv
// Show-ahead request queue between the instruction deserializer and the
// request consumer: circular buffer of {opcode, key_addr, text_addr} entries.
module req_queue #(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [OPCODEW-1:0]         opcode_in,
  input  logic [ADDRW-1:0]           key_addr_in,
  input  logic [ADDRW-1:0]           text_addr_in,
  output logic                       ready_out,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [OPCODEW-1:0]         req_opcode,
  output logic [ADDRW-1:0]           req_key_addr,
  output logic [ADDRW-1:0]           req_text_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int W    = OPCODEW + 2 * ADDRW;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ready_q, ready_d;
  logic            overflow_q, overflow_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [W-1:0]    wdata;
  logic [W-1:0]    head;
  logic [W-1:0]    entries [DEPTH];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = valid_in && !full;
  assign pop   = !empty && req_ready;
  assign wdata = {opcode_in, key_addr_in, text_addr_in};

  // Storage: one register per entry, written only on an accepted push.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry_q;
      logic         we;

      assign we = push && (wr_ptr_q == PTRW'(gi));

      always_ff @(posedge clk) begin
        if (!rst && we) begin
          entry_q <= wdata;
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    // A push attempt against a full queue is dropped and latched as an error.
    if (valid_in && full) begin
      overflow_d = 1'b1;
    end

    // Leave room for the word the deserializer may release one cycle after
    // it samples ready_out.
    ready_d = (count_d <= CNTW'(DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Head is read combinationally; forced to zero when empty so stale or
  // uninitialised storage never shows up on the outputs.
  assign head = entries[rd_ptr_q];

  assign ready_out = ready_q;
  assign req_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign {req_opcode, req_key_addr, req_text_addr} = empty ? '0 : head;

endmodule
